// File: rtl/project_mux_ctrl.sv
// Wishbone-controlled pad multiplexer: routes one of NUM_PROJ projects to the
// pad ring, with a safe-switch hold that parks all pads while swapping.
module project_mux_ctrl #(
  parameter int unsigned NUM_PROJ      = 8,
  parameter int unsigned IO_W          = 38,
  parameter logic [31:0] BASE_ADDR     = 32'h3000_0000,
  parameter int unsigned SWITCH_CYCLES = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     wbs_cyc_i,
  input  logic                     wbs_stb_i,
  input  logic                     wbs_we_i,
  input  logic [3:0]               wbs_sel_i,
  input  logic [31:0]              wbs_adr_i,
  input  logic [31:0]              wbs_dat_i,
  output logic                     wbs_ack_o,
  output logic [31:0]              wbs_dat_o,
  input  logic [IO_W-1:0]          io_in,
  output logic [IO_W-1:0]          io_out,
  output logic [IO_W-1:0]          io_oeb,
  output logic [NUM_PROJ*IO_W-1:0] proj_io_in,
  input  logic [NUM_PROJ*IO_W-1:0] proj_io_out,
  output logic [NUM_PROJ-1:0]      proj_reset,
  output logic [3:0]               active_o,
  output logic                     busy_o
);

  localparam int unsigned HI_W = IO_W - 32;
  localparam logic [7:0]  LAST = 8'(SWITCH_CYCLES - 1);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_HOLD = 1'b1;

  logic [0:0]      state;
  logic [7:0]      count;
  logic [3:0]      active;
  logic [3:0]      target;
  logic [3:0]      pend_target;
  logic            pend;
  logic            err;
  logic            ack;
  logic [31:0]     dat;
  logic [31:0]     oeb_lo [NUM_PROJ];
  logic [HI_W-1:0] oeb_hi [NUM_PROJ];

  logic [31:0]     off;
  logic [3:0]      bank;
  logic            in_win;
  logic            hit_active;
  logic            hit_status;
  logic            hit_oeb;
  logic            access;
  logic            wr;
  logic            act_ok;
  logic            act_bad;
  logic            live;
  logic [31:0]     rdata;
  logic [IO_W-1:0] act_oeb;
  logic [IO_W-1:0] act_out;

  // Address decode: subtraction wraps addresses below BASE_ADDR out of the window.
  always_comb begin
    off        = wbs_adr_i - BASE_ADDR;
    in_win     = off < 32'h200;
    bank       = off[6:3];
    hit_active = in_win && (off[8:0] == 9'h000);
    hit_status = in_win && (off[8:0] == 9'h004);
    hit_oeb    = in_win && (off[8:7] == 2'b10) && (off[1:0] == 2'b00) &&
                 ({28'd0, bank} < NUM_PROJ);
    access     = wbs_cyc_i && wbs_stb_i && (hit_active || hit_status || hit_oeb) && !ack;
    wr         = access && wbs_we_i && (wbs_sel_i == 4'hF);
    act_ok     = wr && hit_active && (wbs_dat_i < NUM_PROJ);
    act_bad    = wr && hit_active && !(wbs_dat_i < NUM_PROJ);
  end

  always_comb begin
    rdata = '0;
    if (hit_active) begin
      rdata = {28'd0, active};
    end else if (hit_status) begin
      rdata = {29'd0, err, pend, state == S_HOLD};
    end else begin
      for (int unsigned p = 0; p < NUM_PROJ; p++) begin
        if (hit_oeb && bank == p[3:0]) begin
          rdata = off[2] ? 32'(oeb_hi[p]) : oeb_lo[p];
        end
      end
    end
  end

  always_comb begin
    act_oeb = '1;
    act_out = '0;
    for (int unsigned p = 0; p < NUM_PROJ; p++) begin
      if (active == p[3:0]) begin
        act_oeb = {oeb_hi[p], oeb_lo[p]};
        act_out = proj_io_out[p*IO_W +: IO_W];
      end
    end
  end

  // Pads are only connected while idle and out of reset; otherwise parked.
  always_comb begin
    live       = (state == S_IDLE) && !reset;
    io_oeb     = live ? act_oeb : '1;
    io_out     = live ? act_out : '0;
    proj_io_in = '0;
    proj_reset = '1;
    for (int unsigned p = 0; p < NUM_PROJ; p++) begin
      if (live && active == p[3:0]) begin
        proj_io_in[p*IO_W +: IO_W] = io_in;
        proj_reset[p]              = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= S_IDLE;
      count       <= '0;
      active      <= '0;
      target      <= '0;
      pend        <= 1'b0;
      pend_target <= '0;
      err         <= 1'b0;
      ack         <= 1'b0;
      dat         <= '0;
      for (int unsigned p = 0; p < NUM_PROJ; p++) begin
        oeb_lo[p] <= '1;
        oeb_hi[p] <= '1;
      end
    end else begin
      ack <= access;
      dat <= (access && !wbs_we_i) ? rdata : '0;

      if (access && !wbs_we_i && hit_status) err <= 1'b0;
      if (act_bad) err <= 1'b1;

      for (int unsigned p = 0; p < NUM_PROJ; p++) begin
        if (wr && hit_oeb && bank == p[3:0]) begin
          if (off[2]) oeb_hi[p] <= wbs_dat_i[HI_W-1:0];
          else        oeb_lo[p] <= wbs_dat_i;
        end
      end

      case (state)
        S_IDLE: begin
          if (act_ok) begin
            target <= wbs_dat_i[3:0];
            count  <= '0;
            state  <= S_HOLD;
          end
        end
        S_HOLD: begin
          if (count == LAST) begin
            active <= target;
            // A request landing on the exit cycle is treated like a pending one.
            if (pend || act_ok) begin
              target <= act_ok ? wbs_dat_i[3:0] : pend_target;
              pend   <= 1'b0;
              count  <= '0;
            end else begin
              state <= S_IDLE;
            end
          end else begin
            count <= count + 8'd1;
            if (act_ok) begin
              pend        <= 1'b1;
              pend_target <= wbs_dat_i[3:0];
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign wbs_ack_o = ack;
  assign wbs_dat_o = dat;
  assign active_o  = active;
  assign busy_o    = (state == S_HOLD);

endmodule

// File: tb/tb_project_mux_ctrl.sv
// Randomized bench for project_mux_ctrl against an event-level model of
// switch timing, pending requests, sticky error and per-project OEB banks.
module tb_project_mux_ctrl;

  localparam int unsigned NP   = 8;
  localparam int unsigned IOW  = 38;
  localparam int unsigned HIW  = IOW - 32;
  localparam int unsigned SC   = 4;
  localparam logic [31:0] BASE = 32'h3000_0000;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic            wbs_cyc_i = 1'b0, wbs_stb_i = 1'b0, wbs_we_i = 1'b0;
  logic [3:0]      wbs_sel_i = '0;
  logic [31:0]     wbs_adr_i = '0, wbs_dat_i = '0;
  logic            wbs_ack_o;
  logic [31:0]     wbs_dat_o;
  logic [IOW-1:0]  io_in = '0, io_out, io_oeb;
  logic [NP*IOW-1:0] proj_io_in, proj_io_out = '0;
  logic [NP-1:0]   proj_reset;
  logic [3:0]      active_o;
  logic            busy_o;

  project_mux_ctrl #(.NUM_PROJ(NP), .IO_W(IOW), .BASE_ADDR(BASE), .SWITCH_CYCLES(SC)) dut (
    .clk(clk), .reset(reset),
    .wbs_cyc_i(wbs_cyc_i), .wbs_stb_i(wbs_stb_i), .wbs_we_i(wbs_we_i),
    .wbs_sel_i(wbs_sel_i), .wbs_adr_i(wbs_adr_i), .wbs_dat_i(wbs_dat_i),
    .wbs_ack_o(wbs_ack_o), .wbs_dat_o(wbs_dat_o),
    .io_in(io_in), .io_out(io_out), .io_oeb(io_oeb),
    .proj_io_in(proj_io_in), .proj_io_out(proj_io_out),
    .proj_reset(proj_reset), .active_o(active_o), .busy_o(busy_o)
  );

  always #5 clk = ~clk;

  int edge_n = 0;
  always @(posedge clk) edge_n++;

  int n_total = 0;
  int n_pass  = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Model: a switch is a window of SC edges ending at m_end; one queued request.
  int            m_active, m_tgt, m_pend_t, m_end;
  bit            m_busy, m_pend, m_err;
  logic [31:0]   m_lo [NP];
  logic [HIW-1:0] m_hi [NP];

  task automatic m_reset();
    m_active = 0; m_busy = 0; m_pend = 0; m_err = 0; m_tgt = 0; m_end = 0;
    for (int p = 0; p < NP; p++) begin
      m_lo[p] = '1;
      m_hi[p] = '1;
    end
  endtask

  task automatic settle(input int n);
    while (m_busy && n >= m_end) begin
      m_active = m_tgt;
      if (m_pend) begin
        m_tgt = m_pend_t; m_pend = 0; m_end += SC;
      end else begin
        m_busy = 0;
      end
    end
  endtask

  function automatic bit decoded(input logic [31:0] off);
    if (off == 0 || off == 4) return 1'b1;
    if (off >= 32'h100 && off < 32'h100 + 8*NP && off % 4 == 0) return 1'b1;
    return 1'b0;
  endfunction

  task automatic m_access(input int e, input logic we, input logic [31:0] off,
                          input logic [31:0] d, input logic [3:0] sel,
                          output logic [31:0] exp);
    int bk;
    settle(e - 1);
    exp = '0;
    bk  = int'((off - 32'h100) / 8);
    if (!we) begin
      if (off == 0) exp = 32'(m_active);
      else if (off == 4) begin
        exp = {29'd0, m_err, m_pend, m_busy};
        m_err = 0;
      end else if (off % 8 == 4) exp = 32'(m_hi[bk]);
      else exp = m_lo[bk];
    end else if (sel == 4'hF) begin
      if (off == 0) begin
        if (d >= NP) m_err = 1;
        else if (m_busy) begin
          m_pend = 1; m_pend_t = int'(d);
        end else begin
          m_busy = 1; m_tgt = int'(d); m_end = e + SC;
        end
      end else if (off >= 32'h100) begin
        if (off % 8 == 4) m_hi[bk] = d[HIW-1:0];
        else m_lo[bk] = d;
      end
    end
    settle(e);
  endtask

  task automatic check_pins();
    logic [IOW-1:0] e_oeb, e_out;
    logic [NP-1:0]  e_rst;
    check("busy", busy_o, m_busy);
    check("active", active_o, m_active);
    if (m_busy) begin
      e_oeb = '1; e_out = '0; e_rst = '1;
    end else begin
      e_oeb = {m_hi[m_active], m_lo[m_active]};
      e_out = proj_io_out[m_active*IOW +: IOW];
      e_rst = '1;
      e_rst[m_active] = 1'b0;
      for (int p = 0; p < NP; p++)
        check("proj_io_in", proj_io_in[p*IOW +: IOW], (p == m_active) ? io_in : '0);
    end
    check("io_oeb", io_oeb, e_oeb);
    check("io_out", io_out, e_out);
    check("proj_reset", proj_reset, e_rst);
  endtask

  task automatic randomize_pads();
    io_in = IOW'({$urandom(), $urandom()});
    for (int i = 0; i < NP*IOW; i++) proj_io_out[i] = 1'($urandom_range(0, 1));
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(negedge clk);
      randomize_pads();
      #1;
      settle(edge_n);
      check_pins();
      check("ack_idle", wbs_ack_o, 1'b0);
      check("dat_idle", wbs_dat_o, 32'd0);
    end
  endtask

  // Caller must be at a negedge; reset is sampled at the next rising edge.
  task automatic do_reset(input int n);
    reset = 1'b1;
    repeat (n) begin
      @(negedge clk);
      #1;
      check("rst_oeb", io_oeb, {IOW{1'b1}});
      check("rst_out", io_out, '0);
      check("rst_proj_reset", proj_reset, {NP{1'b1}});
      check("rst_busy", busy_o, 1'b0);
      check("rst_active", active_o, 4'd0);
      check("rst_ack", wbs_ack_o, 1'b0);
    end
    m_reset();
    reset = 1'b0;
  endtask

  task automatic bus(input logic we, input logic [31:0] adr, input logic [31:0] d,
                     input logic [3:0] sel);
    logic [31:0] off, rd, exp;
    int n, e, lat;
    bit got, dec;
    off = adr - BASE;
    dec = decoded(off);
    @(negedge clk);
    wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_we_i = we;
    wbs_adr_i = adr;  wbs_dat_i = d;    wbs_sel_i = sel;
    got = 0; rd = '0; e = 0;
    for (n = 0; n < 4 && !got; n++) begin
      @(negedge clk);
      if (wbs_ack_o) begin
        got = 1; rd = wbs_dat_o; e = edge_n;
      end else begin
        check("dat_noack", wbs_dat_o, 32'd0);
      end
    end
    wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0; wbs_we_i = 1'b0;
    lat = got ? n : 0;
    check(dec ? "ack_latency" : "no_ack_undecoded", lat, dec ? 1 : 0);
    if (dec && got) begin
      m_access(e, we, off, d, sel, exp);
      if (!we) check("rdata", rd, exp);
    end
    #1;
    settle(edge_n);
    check_pins();
  endtask

  function automatic logic [31:0] oeb_addr(input int p, input bit hi);
    return BASE + 32'h100 + 32'(8*p) + (hi ? 32'd4 : 32'd0);
  endfunction

  logic [31:0] bad_addr [7];

  initial begin
    m_reset();
    bad_addr[0] = BASE + 32'h50;  bad_addr[1] = BASE + 32'h8;
    bad_addr[2] = BASE + 32'h100 + 8*NP; bad_addr[3] = BASE + 32'h102;
    bad_addr[4] = BASE + 32'h200; bad_addr[5] = BASE - 32'd4;
    bad_addr[6] = BASE + 32'h1FC;

    do_reset(3);
    step(2);
    bus(1'b0, BASE, '0, 4'hF);
    check("init_proj_reset", proj_reset, 8'hFE);
    check("init_oeb", io_oeb, {IOW{1'b1}});

    bus(1'b1, oeb_addr(3, 0), 32'hFFFF_00FF, 4'hF);
    bus(1'b1, BASE, 32'd3, 4'hF);
    step(SC + 2);
    check("oeb_lo_p3", io_oeb[31:0], 32'hFFFF_00FF);
    check("active_p3", active_o, 4'd3);

    bus(1'b1, BASE, 32'd9, 4'hF);
    bus(1'b0, BASE + 32'h4, '0, 4'hF);
    bus(1'b0, BASE + 32'h4, '0, 4'hF);
    step(1);

    bus(1'b1, BASE, 32'd2, 4'hF);
    bus(1'b1, BASE, 32'd5, 4'hF);
    bus(1'b0, BASE + 32'h4, '0, 4'hF);
    step(3*SC);
    check("final_active_5", active_o, 4'd5);

    bus(1'b1, BASE, 32'd1, 4'h3);
    bus(1'b0, BASE + 32'h50, '0, 4'hF);
    step(2);

    bus(1'b1, oeb_addr(6, 1), 32'h0000_0015, 4'hF);
    bus(1'b1, BASE, 32'd6, 4'hF);
    step(1);
    do_reset(1);
    step(1);
    for (int p = 0; p < NP; p++) begin
      bus(1'b0, oeb_addr(p, 0), '0, 4'hF);
      bus(1'b0, oeb_addr(p, 1), '0, 4'hF);
    end

    for (int i = 0; i < 250; i++) begin
      int op;
      logic [31:0] d;
      logic [3:0] sel;
      op  = int'($urandom_range(0, 99));
      d   = ($urandom_range(0, 9) == 0) ? $urandom() : 32'($urandom_range(0, NP + 2));
      sel = ($urandom_range(0, 7) == 0) ? 4'($urandom()) : 4'hF;
      if (op < 35)      bus(1'b1, BASE, d, sel);
      else if (op < 50) bus(1'b0, BASE + 32'h4, '0, 4'hF);
      else if (op < 58) bus(1'b0, BASE, '0, 4'hF);
      else if (op < 80) bus(1'b1, oeb_addr(int'($urandom_range(0, NP-1)), 1'($urandom_range(0, 1))),
                            $urandom(), sel);
      else if (op < 92) bus(1'b0, oeb_addr(int'($urandom_range(0, NP-1)), 1'($urandom_range(0, 1))),
                            '0, 4'hF);
      else              bus(1'($urandom_range(0, 1)), bad_addr[$urandom_range(0, 6)], $urandom(), 4'hF);
      step(int'($urandom_range(0, 3)));
      if (i == 180) begin
        do_reset(2);
        step(1);
      end
    end
    step(3*SC + 4);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
